mul_div_core: RTL and testbench

Parametrised iterative multiply/divide unit with architectural HI/LO registers, sitting in the execute stage beside the ALU. It replaces the fixed-latency, externally-wrapped multiplier/divider. Multiply is a single-cycle product held for a programmable latency. Divide is a native restoring radix-2 iterator. Optional multiply-accumulate ops are also supported. It drives the `busy` stall signal consumed by the hazard unit and honours the exception/interrupt request (`req`) suppression rule.

---
 rtl/mdu_pkg.sv | 50 +++++
 rtl/mul_div_core_if.sv | 16 +
 rtl/mdu_div_iter.sv | 53 +++++
 rtl/mul_div_core.sv | 160 ++++++++++++++++
 tb/tb_mul_div_core.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - op codes, FSM states and op-class predicates for mul_div_core
// MDU_MADD_EN enables decoding of the accumulate ops (codes 9-12).
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10,
    OP_MSUB  = 4'd11,
    OP_MSUBU = 4'd12
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL_WAIT,
    DIV_ITER,
    DIV_WAIT
  } mdu_state_e;

`ifdef MDU_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  function automatic logic is_acc_op(input logic [3:0] op);
    return MADD_EN && (op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU});
  endfunction

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op inside {OP_MULT, OP_MULTU}) || is_acc_op(op);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
  endfunction

endpackage

// File: rtl/mul_div_core_if.sv
// rtl/mul_div_core_if.sv - issue/result bundle between the execute stage and mul_div_core
interface mul_div_core_if #(parameter int WIDTH = 32);
  logic             start;
  logic             req;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, req, op, a, b, input out, busy, done, hi, lo);
  modport slave  (input start, req, op, a, b, output out, busy, done, hi, lo);
endinterface

// File: rtl/mdu_div_iter.sv
// rtl/mdu_div_iter.sv - restoring radix-2 divider on unsigned magnitudes, one bit per cycle
module mdu_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             ready
);
  localparam int STEP_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]  rem_q;
  logic [WIDTH-1:0]  quo_q;
  logic [WIDTH-1:0]  div_q;
  logic [STEP_W-1:0] step_q;
  logic [WIDTH:0]    shifted;
  logic [WIDTH:0]    diff;

  // Partial remainder stays below the divisor, so WIDTH+1 bits hold the trial and its sign.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, div_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
      step_q <= '0;
    end else if (start) begin
      rem_q  <= '0;
      quo_q  <= dividend;
      div_q  <= divisor;
      step_q <= STEP_W'(WIDTH);
    end else if (step_q != '0) begin
      step_q <= step_q - 1'b1;
      if (!diff[WIDTH]) begin
        rem_q <= diff[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= shifted[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign ready     = (step_q == '0);
endmodule

// File: rtl/mul_div_core.sv
// rtl/mul_div_core.sv - iterative multiply/divide unit with HI/LO registers and busy stall
// MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU accumulate ops.
module mul_div_core
  import mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 34
) (
  input logic           clk,
  input logic           reset,
  mul_div_core_if.slave bus
);
  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  if (DIV_CYCLES < WIDTH + 1) begin : g_div_cycles_check
    $error("DIV_CYCLES must be at least WIDTH+1");
  end
  if (MUL_CYCLES < 1) begin : g_mul_cycles_check
    $error("MUL_CYCLES must be at least 1");
  end

  mdu_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic                 done_q;
  logic [3:0]           op_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic [WIDTH-1:0]     a_q;
  logic                 a_neg_q, q_neg_q, b_zero_q;

  logic                 go, issue_mul, issue_div, sgn, a_neg, b_neg, commit, div_ready;
  logic [WIDTH-1:0]     a_mag, b_mag, quo, rem, div_hi, div_lo, out_w;
  logic [2*WIDTH-1:0]   a_ext, b_ext, product, mul_res, res;

  assign go        = bus.start & ~bus.req & (state_q == IDLE);
  assign issue_mul = go & is_mul_op(bus.op);
  assign issue_div = go & is_div_op(bus.op);
  assign sgn       = is_signed_op(bus.op);
  assign a_neg     = sgn & bus.a[WIDTH-1];
  assign b_neg     = sgn & bus.b[WIDTH-1];
  assign a_mag     = a_neg ? -bus.a : bus.a;
  assign b_mag     = b_neg ? -bus.b : bus.b;

  // Low 2*WIDTH bits of the extended product are correct for both signednesses.
  assign a_ext   = sgn ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} : {{WIDTH{1'b0}}, bus.a};
  assign b_ext   = sgn ? {{WIDTH{bus.b[WIDTH-1]}}, bus.b} : {{WIDTH{1'b0}}, bus.b};
  assign product = a_ext * b_ext;

  mdu_div_iter #(.WIDTH(WIDTH)) u_div_iter (
    .clk       (clk),
    .reset     (reset),
    .start     (issue_div),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (quo),
    .remainder (rem),
    .ready     (div_ready)
  );

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue_mul)      state_d = MUL_WAIT;
        else if (issue_div) state_d = DIV_ITER;
      end
      MUL_WAIT: begin
        if (cnt_q == CNT_W'(MUL_CYCLES)) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      DIV_ITER: begin
        if (cnt_q == CNT_W'(DIV_CYCLES)) begin
          commit  = 1'b1;
          state_d = IDLE;
        end else if (div_ready) begin
          state_d = DIV_WAIT;
        end
      end
      DIV_WAIT: begin
        if (cnt_q == CNT_W'(DIV_CYCLES)) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sign fixup and the divide-by-zero result are resolved only at commit.
  assign div_lo = b_zero_q ? '1   : (q_neg_q ? -quo : quo);
  assign div_hi = b_zero_q ? a_q  : (a_neg_q ? -rem : rem);

`ifdef MDU_MADD_EN
  always_comb begin
    mul_res = prod_q;
    if (op_q inside {OP_MADD, OP_MADDU})      mul_res = {hi_q, lo_q} + prod_q;
    else if (op_q inside {OP_MSUB, OP_MSUBU}) mul_res = {hi_q, lo_q} - prod_q;
  end
`else
  assign mul_res = prod_q;
`endif

  assign res = is_div_op(op_q) ? {div_hi, div_lo} : mul_res;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      op_q     <= '0;
      prod_q   <= '0;
      a_q      <= '0;
      a_neg_q  <= 1'b0;
      q_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
    end else begin
      done_q <= commit;
      if (go && bus.op == OP_MTHI) hi_q <= bus.a;
      if (go && bus.op == OP_MTLO) lo_q <= bus.a;
      if (commit) {hi_q, lo_q} <= res;
      if (issue_mul || issue_div) begin
        cnt_q    <= CNT_W'(1);
        op_q     <= bus.op;
        prod_q   <= product;
        a_q      <= bus.a;
        a_neg_q  <= a_neg;
        q_neg_q  <= a_neg ^ b_neg;
        b_zero_q <= (bus.b == '0);
      end else if (state_q != IDLE) begin
        cnt_q <= commit ? '0 : cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    out_w = '0;
    case (bus.op)
      OP_MFHI: out_w = hi_q;
      OP_MFLO: out_w = lo_q;
      default: out_w = '0;
    endcase
  end

  assign bus.out  = out_w;
  assign bus.busy = issue_mul | issue_div | (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mul_div_core.sv
// tb/tb_mul_div_core.sv - randomized self-checking bench for mul_div_core (honours MDU_MADD_EN)
module tb_mul_div_core;
  localparam int W     = 32;
  localparam int MUL_N = 5;
  localparam int DIV_N = 34;
`ifdef MDU_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mul_div_core_if #(.WIDTH(W)) bus();

  mul_div_core #(.WIDTH(W), .MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural HI/LO plus remaining busy cycles of the op in flight.
  logic [31:0] m_hi = '0, m_lo = '0;
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [3:0]  m_op = '0;
  logic [63:0] m_res = '0;

  function automatic logic m_is_mul(input logic [3:0] op);
    return op == 4'd1 || op == 4'd2 || (MADD_EN && op >= 4'd9 && op <= 4'd12);
  endfunction

  function automatic logic m_is_div(input logic [3:0] op);
    return op == 4'd3 || op == 4'd4;
  endfunction

  function automatic logic [63:0] ref_product(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    if (op == 4'd1 || op == 4'd9 || op == 4'd11) begin
      sa = $signed(a);
      sb = $signed(b);
      return sa * sb;
    end
    ua = a;
    ub = b;
    return ua * ub;
  endfunction

  function automatic logic [63:0] ref_div(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (op == 4'd3) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      sa = $signed(a);
      sb = $signed(b);
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  always @(negedge clk) begin : model_cmp
    logic        go;
    logic        e_busy;
    logic [31:0] e_out;
    if (!reset) begin
      check("rst_busy", bus.busy, 64'd0);
      check("rst_done", bus.done, 64'd0);
      check("rst_hi", bus.hi, 64'd0);
      check("rst_lo", bus.lo, 64'd0);
      m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0;
    end else begin
      go     = bus.start && !bus.req && m_left == 0;
      e_busy = (m_left != 0) || (go && (m_is_mul(bus.op) || m_is_div(bus.op)));
      e_out  = (bus.op == 4'd5) ? m_hi : (bus.op == 4'd6) ? m_lo : 32'd0;
      check("busy", bus.busy, e_busy);
      check("done", bus.done, m_done);
      check("hi", bus.hi, m_hi);
      check("lo", bus.lo, m_lo);
      check("out", bus.out, e_out);
      m_done = 1'b0;
      if (m_left != 0) begin
        m_left--;
        if (m_left == 0) begin
          if (m_op == 4'd9 || m_op == 4'd10)       {m_hi, m_lo} = {m_hi, m_lo} + m_res;
          else if (m_op == 4'd11 || m_op == 4'd12) {m_hi, m_lo} = {m_hi, m_lo} - m_res;
          else                                     {m_hi, m_lo} = m_res;
          m_done = 1'b1;
        end
      end else if (go) begin
        m_op = bus.op;
        if (bus.op == 4'd7) m_hi = bus.a;
        else if (bus.op == 4'd8) m_lo = bus.a;
        else if (m_is_mul(bus.op)) begin
          m_left = MUL_N;
          m_res  = ref_product(bus.op, bus.a, bus.b);
        end else if (m_is_div(bus.op)) begin
          m_left = DIV_N;
          m_res  = ref_div(bus.op, bus.a, bus.b);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    tick();
    bus.start = 1'b0; bus.op = 4'd0;
  endtask

  // Called in cycle t+1 of an issue; returns the cycle offset at which done was seen.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!bus.done && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic wait_idle();
    int i = 0;
    bus.start = 1'b0; bus.req = 1'b0; bus.op = 4'd0;
    while (bus.busy && i < 100) begin
      tick();
      i++;
    end
    check("idle_timeout", bus.busy, 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return $urandom_range(0, 20);
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int lat;
    reset = 1'b0;
    bus.start = 1'b0; bus.req = 1'b0; bus.op = 4'd0; bus.a = '0; bus.b = '0;
    repeat (3) tick();
    check("reset_out", bus.out, 64'd0);
    check("reset_busy", bus.busy, 64'd0);
    reset = 1'b1;
    tick();

    bus.start = 1'b1; bus.op = 4'd7; bus.a = 32'h1234;
    #1 check("mthi_busy", bus.busy, 64'd0);
    tick();
    bus.op = 4'd8; bus.a = 32'hABCD;
    tick();
    bus.start = 1'b0; bus.op = 4'd5;
    #1 check("mfhi", bus.out, 64'h1234);
    bus.op = 4'd6;
    #1 check("mflo", bus.out, 64'hABCD);
    tick();

    bus.start = 1'b1; bus.op = 4'd1; bus.a = 32'hFFFF_FFFE; bus.b = 32'd3;
    #1 check("mult_issue_busy", bus.busy, 64'd1);
    tick();
    bus.start = 1'b0; bus.op = 4'd0;
    wait_done(lat);
    check("mult_latency", lat, MUL_N + 1);
    check("mult_hi", bus.hi, 64'hFFFF_FFFF);
    check("mult_lo", bus.lo, 64'hFFFF_FFFA);

    issue(4'd2, 32'hFFFF_FFFE, 32'd3);
    wait_done(lat);
    check("multu_hi", bus.hi, 64'h2);
    check("multu_lo", bus.lo, 64'hFFFF_FFFA);

    issue(4'd3, -32'sd7, 32'd2);
    wait_done(lat);
    check("div_latency", lat, DIV_N + 1);
    check("div_lo", bus.lo, 64'hFFFF_FFFD);
    check("div_hi", bus.hi, 64'hFFFF_FFFF);

    issue(4'd4, 32'd7, 32'd0);
    wait_done(lat);
    check("divu0_lo", bus.lo, 64'hFFFF_FFFF);
    check("divu0_hi", bus.hi, 64'd7);

    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat);
    check("divmin_lo", bus.lo, 64'h8000_0000);
    check("divmin_hi", bus.hi, 64'd0);

    bus.start = 1'b1; bus.req = 1'b1; bus.op = 4'd1; bus.a = 32'd5; bus.b = 32'd7;
    #1 check("req_busy", bus.busy, 64'd0);
    tick();
    bus.start = 1'b0; bus.req = 1'b0; bus.op = 4'd0;
    tick();
    check("req_hi", bus.hi, 64'd0);
    check("req_lo", bus.lo, 64'h8000_0000);

    issue(4'd1, 32'd5, 32'd6);
    tick();
    tick();
    bus.start = 1'b1; bus.op = 4'd4; bus.a = 32'd100; bus.b = 32'd3;
    tick();
    bus.start = 1'b0; bus.op = 4'd0;
    wait_done(lat);
    check("ignored_hi", bus.hi, 64'd0);
    check("ignored_lo", bus.lo, 64'h1E);
    tick();
    check("ignored_idle", bus.busy, 64'd0);

    issue(4'd7, 32'd0, 32'd0);
    issue(4'd8, 32'hFFFF_FFFF, 32'd0);
    if (MADD_EN) begin
      issue(4'd10, 32'd1, 32'd1);
      wait_done(lat);
      check("maddu_hi", bus.hi, 64'd1);
      check("maddu_lo", bus.lo, 64'd0);
    end else begin
      bus.start = 1'b1; bus.op = 4'd10; bus.a = 32'd1; bus.b = 32'd1;
      #1 check("maddu_off_busy", bus.busy, 64'd0);
      tick();
      bus.start = 1'b0; bus.op = 4'd0;
      tick();
      check("maddu_off_hi", bus.hi, 64'd0);
      check("maddu_off_lo", bus.lo, 64'hFFFF_FFFF);
    end

    for (int i = 0; i < 600; i++) begin
      bus.start = ($urandom_range(0, 3) != 0);
      bus.req   = ($urandom_range(0, 7) == 0);
      bus.op    = 4'($urandom_range(0, 15));
      bus.a     = pick();
      bus.b     = pick();
      tick();
    end
    wait_idle();

    issue(4'd7, 32'h55, 32'd0);
    issue(4'd8, 32'h66, 32'd0);
    issue(4'd3, 32'd1000, 32'd7);
    repeat (9) tick();
    reset = 1'b0;
    #1;
    check("abort_busy", bus.busy, 64'd0);
    check("abort_done", bus.done, 64'd0);
    check("abort_hi", bus.hi, 64'd0);
    check("abort_lo", bus.lo, 64'd0);
    tick();
    tick();
    reset = 1'b1;
    bus.op = 4'd6;
    #1 check("abort_mflo", bus.out, 64'd0);
    tick();
    bus.op = 4'd0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
